muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, in, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, in, 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port startE, in, 1: a mult/div instruction is valid in Execute.
REQ-004 SHALL have port opE, in, 2: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port srcaE, in, 32: multiplicand/dividend; also mthi/mtlo write data.
REQ-006 SHALL have port srcbE, in, 32: multiplier/divisor.
REQ-007 SHALL have ports hienE and loenE, in, 1 each: mthi/mtlo write enables, matching the controller's hienE/loenE.
REQ-008 SHALL have port hiloselE, in, 1: read select for hiloE; 1 selects HI, 0 selects LO.
REQ-009 SHALL have port hiloE, out, 32: combinational read of the selected HI/LO register.
REQ-010 SHALL have port busyE, out, 1: unit is mid-operation; the hazard unit stalls any mult/div/mfhi/mflo/mthi/mtlo while it is high.
REQ-011 SHALL have port doneE, out, 1: one-cycle pulse when HI/LO receive a new result.

Function
REQ-012 FSM states SHALL be IDLE, ITER, FIXUP, DONE; busyE = (state is ITER or FIXUP), doneE = (state is DONE).
REQ-013 In IDLE or DONE, startE=1 SHALL latch operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned), result-sign flags and the op; the FSM then enters ITER with a 5-bit counter at 0.
REQ-014 ITER SHALL run exactly 32 cycles: multiply uses a shift-add step per cycle on a 64-bit accumulator; divide uses a restoring shift-subtract step per cycle producing one quotient bit; the counter wraps 31->0 on entry to FIXUP.
REQ-015 FIXUP (1 cycle) SHALL apply signs and write HI/LO: product is negated if operand signs differ (HI=upper 32, LO=lower 32); quotient to LO, negated if signs differ; remainder to HI, sign follows dividend.
REQ-016 DONE (1 cycle) SHALL return to IDLE, or behave as IDLE for a new startE.
REQ-017 Latency: for startE sampled at edge T0, busyE SHALL be high from T0 through T33 (33 cycles), HI/LO SHALL be updated at T33, and doneE SHALL be high for the cycle after T33.
REQ-018 Divide by zero SHALL complete with normal latency and give LO=0xFFFFFFFF, HI=dividend (original srcaE).
REQ-019 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 startE, hienE and loenE SHALL be ignored while busyE=1.
REQ-021 When not busy, hienE SHALL write srcaE to HI and loenE SHALL write srcaE to LO on the edge. If startE is also high in the same cycle, startE wins and the write is dropped.
REQ-022 hiloE SHALL always reflect the current registered HI/LO; there is no bypass of an in-flight result.

Reset
REQ-023 On reset, the FSM SHALL go to IDLE, HI, LO, the accumulator and the counter SHALL go to 0, and busyE=0, doneE=0, hiloE=0.
REQ-024 Reset asserted mid-operation SHALL abort it with no HI/LO update. The first startE after reset deasserts SHALL begin a fresh operation.

Verification
REQ-025 multu 0xFFFFFFFF x 0xFFFFFFFF -> busyE high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, doneE pulses once.
REQ-026 mult 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-027 div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-028 divu 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-029 Start mult 2x3, pulse startE and hienE with srcaE=0xDEAD at cycle 5 -> both ignored; final HI=0, LO=6.
REQ-030 Start divu, assert reset at cycle 10 -> busyE=0 immediately, HI=LO=0; then mtlo 0x1234 with hiloselE=0 -> hiloE=0x1234 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide; 33-cycle busy window per operation.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        hienE,
    input  logic        loenE,
    input  logic        hiloselE,
    output logic [31:0] hiloE,
    output logic        busyE,
    output logic        doneE
);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic        negr_q, negr_d;

    logic        sign_op, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_sh, div_diff;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    assign busyE = (state_q == ITER) || (state_q == FIXUP);
    assign doneE = (state_q == DONE);
    assign hiloE = hiloselE ? hi_q : lo_q;

    always_comb begin
        sign_op  = ~opE[0];
        a_neg    = sign_op & srcaE[31];
        b_neg    = sign_op & srcbE[31];
        a_mag    = a_neg ? -srcaE : srcaE;
        b_mag    = b_neg ? -srcbE : srcbE;
        b_zero   = (srcbE == 32'd0);

        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_sh   = acc_q[63:31];
        div_diff = div_sh - {1'b0, opnd_q};

        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem      = negr_q ? -acc_q[63:32] : acc_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        negr_d  = negr_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (startE) begin
                    state_d = ITER;
                    cnt_d   = 5'd0;
                    div_d   = opE[1];
                    opnd_d  = opE[1] ? b_mag : a_mag;
                    acc_d   = {32'd0, opE[1] ? a_mag : b_mag};
                    // A zero divisor keeps the all-ones quotient unsigned
                    neg_d   = (a_neg ^ b_neg) & ~(opE[1] & b_zero);
                    negr_d  = opE[1] & a_neg;
                end else begin
                    if (hienE) hi_d = srcaE;
                    if (loenE) lo_d = srcaE;
                end
            end
            ITER: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIXUP;
                if (!div_q)
                    acc_d = {mul_sum, acc_q[31:1]};
                else if (div_diff[32])
                    acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
                else
                    acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
            FIXUP: begin
                state_d = DONE;
                if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Expected HI/LO pairs are queued at issue and popped when doneE fires.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        hienE;
    logic        loenE;
    logic        hiloselE;
    logic [31:0] hiloE;
    logic        busyE;
    logic        doneE;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .startE  (startE),
        .opE     (opE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .hienE   (hienE),
        .loenE   (loenE),
        .hiloselE(hiloselE),
        .hiloE   (hiloE),
        .busyE   (busyE),
        .doneE   (doneE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sbv, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        model = 64'd0;
        case (op)
            2'b00: model = sa * sbv;
            2'b01: model = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    sq = sa / sbv;
                    sr = sa % sbv;
                    model = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    model = {ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        sb_q.push_back(exp);
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    task automatic wait_check(input string tag, input int pre);
        int busy = pre;
        int cyc = 0;
        logic [63:0] e;
        while (!doneE && cyc < 100) begin
            @(negedge clk);
            if (busyE) busy++;
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'd0, doneE}, 32'd1);
        chk({tag, "_busy_cycles"}, busy, 32'd33);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        hiloselE = 1'b1;
        #1 chk({tag, "_hi"}, hiloE, e[63:32]);
        hiloselE = 1'b0;
        #1 chk({tag, "_lo"}, hiloE, e[31:0]);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, doneE}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        start_op(op, a, b, exp);
        wait_check(tag, 0);
    endtask

    task automatic mt(input logic hi, input logic [31:0] v);
        @(negedge clk);
        hienE = hi;
        loenE = ~hi;
        srcaE = v;
        @(posedge clk);
        #1;
        hienE = 1'b0;
        loenE = 1'b0;
    endtask

    initial begin
        int pre;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        reset    = 1'b1;
        startE   = 1'b0;
        opE      = 2'b00;
        srcaE    = 32'd0;
        srcbE    = 32'd0;
        hienE    = 1'b0;
        loenE    = 1'b0;
        hiloselE = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busyE}, 32'd0);
        chk("rst_done", {31'd0, doneE}, 32'd0);
        chk("rst_lo", hiloE, 32'd0);
        hiloselE = 1'b1;
        #1 chk("rst_hi", hiloE, 32'd0);
        hiloselE = 1'b0;
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5,
               64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0,
               64'h0000_0064_FFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FFF0, 32'd0,
               64'hFFFF_FFF0_FFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            rop = 2'(i % 4);
            ra  = $urandom;
            rb  = (i == 6) ? 32'd3 : $urandom;
            run_op("rand", rop, ra, rb, model(rop, ra, rb));
        end

        mt(1'b1, 32'h0000_0BAD);
        hiloselE = 1'b1;
        #1 chk("mthi", hiloE, 32'h0000_0BAD);
        hiloselE = 1'b0;

        start_op(2'b00, 32'd2, 32'd3, 64'h0000_0000_0000_0006);
        pre = 0;
        repeat (5) begin
            @(negedge clk);
            if (busyE) pre++;
        end
        startE = 1'b1;
        hienE  = 1'b1;
        opE    = 2'b11;
        srcaE  = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        startE = 1'b0;
        hienE  = 1'b0;
        hiloselE = 1'b1;
        #1 chk("busy_mthi_ignored", hiloE, 32'h0000_0BAD);
        hiloselE = 1'b0;
        wait_check("busy_ignore", pre);

        mt(1'b0, 32'h0000_0055);
        @(negedge clk);
        startE = 1'b1;
        loenE  = 1'b1;
        opE    = 2'b01;
        srcaE  = 32'h0000_0099;
        srcbE  = 32'd2;
        sb_q.push_back(64'h0000_0000_0000_0132);
        @(posedge clk);
        #1;
        startE = 1'b0;
        loenE  = 1'b0;
        chk("start_beats_mtlo", hiloE, 32'h0000_0055);
        wait_check("start_win", 0);

        start_op(2'b11, 32'd1000, 32'd7, 64'd0);
        void'(sb_q.pop_back());
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busyE}, 32'd0);
        chk("abort_lo", hiloE, 32'd0);
        hiloselE = 1'b1;
        #1 chk("abort_hi", hiloE, 32'd0);
        hiloselE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pre = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneE || busyE) pre++;
        end
        chk("abort_quiet", pre, 32'd0);
        chk("abort_lo_kept", hiloE, 32'd0);

        mt(1'b0, 32'h0000_1234);
        chk("mtlo_after_rst", hiloE, 32'h0000_1234);

        run_op("post_rst", 2'b11, 32'd1000, 32'd7,
               64'h0000_0006_0000_008E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
